// File: rtl/pkt_beat_tracker.sv
// Tracks header/payload beats of an AXI-Stream packet against the length
// reported by the length finder, flagging short/long packets and counting outcomes.
module pkt_beat_tracker #(
  parameter int TDATA_WIDTH    = 64,
  parameter int MAX_PKT_LENGTH = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      s_tvalid,
  input  logic                      s_tready,
  input  logic                      s_tlast,
  input  logic [MAX_PKT_LENGTH:0]   pkt_length,
  output logic                      hdr_beat,
  output logic                      pipe_stall,
  output logic [MAX_PKT_LENGTH:0]   beats_remaining,
  output logic                      pkt_done,
  output logic                      err_short,
  output logic                      err_long,
  output logic [15:0]               pkt_count,
  output logic [15:0]               err_count
);
  localparam int BYTES = TDATA_WIDTH / 8;
  localparam int W     = MAX_PKT_LENGTH + 1;

  typedef enum logic [1:0] {IDLE, PAYLOAD, DRAIN} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   rem_nxt;
  logic           done_nxt, short_nxt, long_nxt;
  logic           accept;
  logic [W:0]     len_rnd;
  logic [W-1:0]   n_beats;

  // One spare bit so the round-up add cannot wrap before the divide.
  assign len_rnd = {1'b0, pkt_length} + (W+1)'(BYTES - 1);
  assign n_beats = W'(len_rnd / (W+1)'(BYTES));

  assign accept     = s_tvalid & s_tready;
  assign hdr_beat   = s_tvalid && (state == IDLE);
  assign pipe_stall = (state == PAYLOAD) || (state == DRAIN);

  always_comb begin
    state_nxt = state;
    rem_nxt   = beats_remaining;
    done_nxt  = 1'b0;
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (n_beats == '0) begin
            if (s_tlast) done_nxt = 1'b1;
            else begin
              long_nxt  = 1'b1;
              state_nxt = DRAIN;
            end
          end else if (s_tlast) begin
            short_nxt = 1'b1;
          end else begin
            rem_nxt   = n_beats;
            state_nxt = PAYLOAD;
          end
        end
        PAYLOAD: begin
          rem_nxt = beats_remaining - W'(1);
          if (beats_remaining == W'(1)) begin
            if (s_tlast) begin
              done_nxt  = 1'b1;
              state_nxt = IDLE;
            end else begin
              long_nxt  = 1'b1;
              state_nxt = DRAIN;
            end
          end else if (s_tlast) begin
            short_nxt = 1'b1;
            rem_nxt   = '0;
            state_nxt = IDLE;
          end
        end
        DRAIN: if (s_tlast) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state           <= IDLE;
      beats_remaining <= '0;
      pkt_done        <= 1'b0;
      err_short       <= 1'b0;
      err_long        <= 1'b0;
      pkt_count       <= '0;
      err_count       <= '0;
    end else begin
      state           <= state_nxt;
      beats_remaining <= rem_nxt;
      pkt_done        <= done_nxt;
      err_short       <= short_nxt;
      err_long        <= long_nxt;
      if (done_nxt && pkt_count != 16'hFFFF)
        pkt_count <= pkt_count + 16'd1;
      if ((short_nxt || long_nxt) && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_pkt_beat_tracker.sv
// Directed bench for pkt_beat_tracker with 8-byte beats and hand-computed expectations.
module tb_pkt_beat_tracker;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic        s_tvalid, s_tready, s_tlast;
  logic [16:0] pkt_length;
  logic        hdr_beat, pipe_stall, pkt_done, err_short, err_long;
  logic [16:0] beats_remaining;
  logic [15:0] pkt_count, err_count;

  int errors = 0;
  int checks = 0;

  pkt_beat_tracker #(.TDATA_WIDTH(64), .MAX_PKT_LENGTH(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .pkt_length(pkt_length),
    .hdr_beat(hdr_beat), .pipe_stall(pipe_stall), .beats_remaining(beats_remaining),
    .pkt_done(pkt_done), .err_short(err_short), .err_long(err_long),
    .pkt_count(pkt_count), .err_count(err_count)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a beat shortly after a rising edge, clock it, settle past the edge.
  task automatic step(input logic v, input logic r, input logic l, input logic [16:0] len);
    s_tvalid = v; s_tready = r; s_tlast = l; pkt_length = len;
    @(posedge aclk); #1;
  endtask

  task automatic outs(input string tag, input logic [16:0] rem, input logic stall,
                      input logic d, input logic s, input logic lg,
                      input logic [15:0] pc, input logic [15:0] ec);
    chk({tag, ".rem"},   32'(beats_remaining), 32'(rem));
    chk({tag, ".stall"}, 32'(pipe_stall), 32'(stall));
    chk({tag, ".pulse"}, {29'd0, pkt_done, err_short, err_long}, {29'd0, d, s, lg});
    chk({tag, ".pcnt"},  32'(pkt_count), 32'(pc));
    chk({tag, ".ecnt"},  32'(err_count), 32'(ec));
  endtask

  initial begin
    aresetn = 1'b0; s_tvalid = 0; s_tready = 0; s_tlast = 0; pkt_length = '0;
    #2;
    outs("reset", 0, 0, 0, 0, 0, 0, 0);
    @(posedge aclk); #1;
    aresetn = 1'b1;

    // 24 bytes -> 3 beats, exact length
    s_tvalid = 1; #1; chk("t1.hdr", 32'(hdr_beat), 1);
    step(1, 1, 0, 17'd24);  outs("t1.h",  3, 1, 0, 0, 0, 0, 0);
    s_tvalid = 1; #1; chk("t1.nohdr", 32'(hdr_beat), 0);
    step(1, 1, 0, 17'd0);   outs("t1.b1", 2, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 17'd0);   outs("t1.b2", 1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 17'd0);   outs("t1.b3", 0, 0, 1, 0, 0, 1, 0);
    step(0, 1, 0, 17'd0);   outs("t1.idle", 0, 0, 0, 0, 0, 1, 0);

    // 20 bytes -> 3 beats, tlast on 2nd payload beat
    step(1, 1, 0, 17'd20);  outs("t2.h",  3, 1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 17'd0);   outs("t2.b1", 2, 1, 0, 0, 0, 1, 0);
    step(1, 1, 1, 17'd0);   outs("t2.b2", 0, 0, 0, 1, 0, 1, 1);

    // 8 bytes -> 1 beat, tlast late
    step(1, 1, 0, 17'd8);   outs("t3.h",  1, 1, 0, 0, 0, 1, 1);
    step(1, 1, 0, 17'd0);   outs("t3.b1", 0, 1, 0, 0, 1, 1, 2);
    step(1, 1, 0, 17'd0);   outs("t3.drn", 0, 1, 0, 0, 0, 1, 2);
    step(1, 1, 1, 17'd0);   outs("t3.b2", 0, 0, 0, 0, 0, 1, 2);

    // Zero-length packets and a header carrying tlast with payload owed
    step(1, 1, 1, 17'd0);   outs("t4.z",  0, 0, 1, 0, 0, 2, 2);
    step(1, 1, 0, 17'd0);   outs("t4.zl", 0, 1, 0, 0, 1, 2, 3);
    step(1, 1, 1, 17'd0);   outs("t4.zd", 0, 0, 0, 0, 0, 2, 3);
    step(1, 1, 1, 17'd1);   outs("t4.hs", 0, 0, 0, 1, 0, 2, 4);
    step(1, 0, 1, 17'd0);   outs("t4.nordy", 0, 0, 0, 0, 0, 2, 4);

    // 16 bytes -> 2 beats with tready toggling
    step(1, 1, 0, 17'd16);  outs("t5.h",  2, 1, 0, 0, 0, 2, 4);
    step(1, 0, 0, 17'd0);   outs("t5.s1", 2, 1, 0, 0, 0, 2, 4);
    step(1, 1, 0, 17'd0);   outs("t5.b1", 1, 1, 0, 0, 0, 2, 4);
    step(1, 0, 1, 17'd0);   outs("t5.s2", 1, 1, 0, 0, 0, 2, 4);
    step(1, 1, 1, 17'd0);   outs("t5.b2", 0, 0, 1, 0, 0, 3, 4);

    // Back-to-back: header in the cycle right after tlast
    step(1, 1, 0, 17'd8);   outs("t6.h1", 1, 1, 0, 0, 0, 3, 4);
    step(1, 1, 1, 17'd0);   outs("t6.b1", 0, 0, 1, 0, 0, 4, 4);
    s_tvalid = 1; s_tlast = 0; #1; chk("t6.hdr", 32'(hdr_beat), 1);
    step(1, 1, 0, 17'd9);   outs("t6.h2", 2, 1, 0, 0, 0, 4, 4);
    step(1, 1, 0, 17'd0);   outs("t6.c1", 1, 1, 0, 0, 0, 4, 4);
    step(1, 1, 1, 17'd0);   outs("t6.c2", 0, 0, 1, 0, 0, 5, 4);

    // Reset mid-packet, no clock edge needed to clear
    step(1, 1, 0, 17'd40);  outs("t7.h", 5, 1, 0, 0, 0, 5, 4);
    s_tvalid = 0;
    aresetn = 1'b0; #2;
    outs("t7.rst", 0, 0, 0, 0, 0, 0, 0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    step(1, 1, 0, 17'd8);   outs("t7.h2", 1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 17'd0);   outs("t7.b1", 0, 0, 1, 0, 0, 1, 0);

    // Saturation: a stream of zero-length single-beat packets
    s_tvalid = 1; s_tready = 1; s_tlast = 1; pkt_length = '0;
    repeat (65540) @(posedge aclk);
    #1;
    chk("sat.pcnt", 32'(pkt_count), 32'hFFFF);
    chk("sat.ecnt", 32'(err_count), 32'd0);
    s_tvalid = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pkt_beat_tracker.md
PKT_BEAT_TRACKER -- requirements
Module: pkt_beat_tracker

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 64, meaning AXI-Stream data width in bits; legal values are multiples of 8, at least 8.
REQ-002 SHALL have parameter MAX_PKT_LENGTH, default 16, meaning the width of the payload-length field in bytes.
REQ-003 SHALL have port aclk, input, 1 bit: the single clock.
REQ-004 SHALL have port aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port s_tvalid, input, 1 bit: stream beat valid.
REQ-006 SHALL have port s_tready, input, 1 bit: stream beat ready. The block only observes it and never drives it.
REQ-007 SHALL have port s_tlast, input, 1 bit: last beat of the packet.
REQ-008 SHALL have port pkt_length, input, MAX_PKT_LENGTH+1 bits: payload length in bytes, excluding the header, from the length finder. It is valid during the header beat.
REQ-009 SHALL have port hdr_beat, output, 1 bit: the current beat is a header.
REQ-010 SHALL have port pipe_stall, output, 1 bit: holds the parser pipeline stages while payload is in flight.
REQ-011 SHALL have port beats_remaining, output, MAX_PKT_LENGTH+1 bits: expected payload beats not yet accepted.
REQ-012 SHALL have port pkt_done, output, 1 bit: one-cycle pulse, packet completed with the correct length.
REQ-013 SHALL have port err_short, output, 1 bit: one-cycle pulse, tlast arrived before the expected count.
REQ-014 SHALL have port err_long, output, 1 bit: one-cycle pulse, the count expired without tlast.
REQ-015 SHALL have port pkt_count, output, 16 bits: number of packets completed correctly.
REQ-016 SHALL have port err_count, output, 16 bits: number of length errors.

Function
REQ-017 A beat SHALL count as accepted only in a cycle where s_tvalid and s_tready are both 1.
REQ-018 BYTES SHALL equal TDATA_WIDTH/8.
REQ-019 Expected payload beats N SHALL equal ceil(pkt_length/BYTES), computed at full width without truncation.
REQ-020 The FSM SHALL have exactly three states: IDLE (awaiting header), PAYLOAD and DRAIN (discarding until tlast).
REQ-021 hdr_beat SHALL equal s_tvalid AND (state==IDLE), combinationally.
REQ-022 pipe_stall SHALL be 1 exactly when the state is PAYLOAD or DRAIN, decoded from the registered state only.
REQ-023 Header accepted in IDLE, N==0, tlast=1: SHALL pulse pkt_done and stay in IDLE.
REQ-024 Header accepted in IDLE, N==0, tlast=0: SHALL pulse err_long and go to DRAIN.
REQ-025 Header accepted in IDLE, N>0, tlast=1: SHALL pulse err_short and stay in IDLE.
REQ-026 Header accepted in IDLE, N>0, tlast=0: SHALL load beats_remaining with N and go to PAYLOAD.
REQ-027 In PAYLOAD, each accepted beat SHALL decrement beats_remaining by 1.
REQ-028 In PAYLOAD, beats_remaining==1 and tlast=1: SHALL pulse pkt_done and go to IDLE.
REQ-029 In PAYLOAD, beats_remaining==1 and tlast=0: SHALL pulse err_long and go to DRAIN.
REQ-030 In PAYLOAD, beats_remaining>1 and tlast=1: SHALL pulse err_short, clear beats_remaining and go to IDLE.
REQ-031 In DRAIN, an accepted beat with tlast=1 SHALL return the FSM to IDLE with no further pulse; other beats are ignored.
REQ-032 pkt_done, err_short and err_long SHALL be registered and asserted in the cycle after the deciding beat; at most one of them is high in any cycle.
REQ-033 pkt_count SHALL increment on every pkt_done pulse; err_count SHALL increment on every err_short or err_long pulse.
REQ-034 Both counters SHALL saturate at 16'hFFFF.
REQ-035 Cycles with s_tvalid=1 and s_tready=0 SHALL change no state and no counter.
REQ-036 A header SHALL be accepted in the cycle immediately after the FSM returns to IDLE, with no bubble required.

Reset
REQ-037 While aresetn=0, state SHALL be IDLE and beats_remaining, pkt_done, err_short, err_long, pkt_count and err_count SHALL all be 0, independent of aclk.
REQ-038 Reset asserted mid-packet SHALL abort tracking without any error pulse. After release, the next accepted beat is treated as a header.

Verification
REQ-039 With BYTES=8: header with pkt_length=24 and tlast=0, then 3 payload beats with tlast on the 3rd -> pipe_stall=1 for 3 cycles, beats_remaining steps 3,2,1,0, pkt_done pulses once, pkt_count=1.
REQ-040 With BYTES=8: pkt_length=20 -> N=3; tlast on the 2nd payload beat -> err_short pulse, state IDLE, err_count=1, pkt_count unchanged.
REQ-041 With BYTES=8: pkt_length=8, then 2 payload beats with tlast on the 2nd -> err_long after the 1st payload beat, DRAIN, IDLE after the 2nd beat, err_count=1.
REQ-042 pkt_length=0 with tlast on the header -> pkt_done and pipe_stall never asserted. pkt_length=16 with s_tready toggling 1/0 every cycle -> counts only accepted beats, pkt_done after the 2nd accepted payload beat.
REQ-043 aresetn pulled low with beats_remaining=5 -> all outputs 0 immediately; after release, a new header with pkt_length=8 completes normally with pkt_count=1.
REQ-044 Back-to-back packets: the header arrives in the cycle after tlast -> accepted as a header (hdr_beat=1), with no beat lost.
